// File: rtl/word_divider_pkg.sv
// Shared word-size macros and the divider state encoding.
// Imported by word_divider and word_div_step.
`ifndef WORD_DIVIDER_PKG_MACROS
`define WORD_DIVIDER_PKG_MACROS
`define WordWidth 32
`define WordZero {`WordWidth{1'b0}}
`endif

package word_divider_pkg;

   localparam int WORD_WIDTH = `WordWidth;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/word_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep either the difference or the shifted remainder.
module word_div_step
   import word_divider_pkg::*;
#(
   parameter int WIDTH = `WordWidth
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             quo_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff_lo;
   logic [1:0]       diff_hi;

   // The full remainder is kept in the shifted value so divisors with the MSB
   // set still compare correctly; a non-negative difference always fits WIDTH bits.
   always_comb begin
      shifted            = {rem, next_bit};
      {diff_hi, diff_lo} = {1'b0, shifted} - {2'b00, divisor};
      quo_bit            = (diff_hi == 2'b00);
      rem_next           = quo_bit ? diff_lo : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/word_divider.sv
// Multi-cycle restoring divider (IDLE/CALC/FIX). Optional signed mode is enabled
// with the macro WORD_DIVIDER_SIGNED_EN, which adds the in_Signed port.
module word_divider
   import word_divider_pkg::*;
#(
   parameter int WIDTH = `WordWidth
) (
   input  logic             clock,
   input  logic             in_nReset,
   input  logic             in_Start,
   input  logic [WIDTH-1:0] in_Dividend,
   input  logic [WIDTH-1:0] in_Divisor,
`ifdef WORD_DIVIDER_SIGNED_EN
   input  logic             in_Signed,
`endif
   output logic             out_Busy,
   output logic             out_Done,
   output logic [WIDTH-1:0] out_Quotient,
   output logic [WIDTH-1:0] out_Remainder,
   output logic             out_Zero,
   output logic             out_Neg,
   output logic             out_Overflow,
   output logic             out_DivZero,
   output div_state_t       out_State
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic             start_acc, calc_en, fix_en, last_iter, in_dz;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dvd_q, dvs_q, rem_q, orig_q;
   logic             dz_q;
   logic [WIDTH-1:0] dvd_mag, dvs_mag, step_rem, q_fix, r_fix;
   logic             step_bit;

   assign in_dz     = (in_Divisor == '0);
   assign last_iter = (cnt_q == LAST_ITER);

`ifdef WORD_DIVIDER_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};

   logic neg_quo_q, neg_rem_q, ovf_q;

   // Signed operands are iterated as magnitudes; signs are restored in FIX.
   always_comb begin
      dvd_mag = (in_Signed && in_Dividend[WIDTH-1]) ? -in_Dividend : in_Dividend;
      dvs_mag = (in_Signed && in_Divisor[WIDTH-1])  ? -in_Divisor  : in_Divisor;
   end

   always_ff @(posedge clock or negedge in_nReset) begin
      if (!in_nReset) begin
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (start_acc) begin
         neg_quo_q <= in_Signed && (in_Dividend[WIDTH-1] ^ in_Divisor[WIDTH-1]);
         neg_rem_q <= in_Signed && in_Dividend[WIDTH-1];
         ovf_q     <= in_Signed && (in_Dividend == MIN_WORD) && (in_Divisor == '1);
      end
   end
`else
   assign dvd_mag = in_Dividend;
   assign dvs_mag = in_Divisor;
`endif

   word_div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .next_bit (dvd_q[WIDTH-1]),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_bit  (step_bit)
   );

   always_ff @(posedge clock or negedge in_nReset) begin
      if (!in_nReset) state_q <= DIV_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: if (in_Start) state_d = in_dz ? DIV_FIX : DIV_CALC;
         DIV_CALC: if (last_iter) state_d = DIV_FIX;
         DIV_FIX:  state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      out_Busy  = (state_q != DIV_IDLE);
      start_acc = (state_q == DIV_IDLE) && in_Start;
      calc_en   = (state_q == DIV_CALC);
      fix_en    = (state_q == DIV_FIX);
      out_State = state_q;
   end

   // The dividend register doubles as the quotient: each shift frees the LSB
   // for the freshly produced quotient bit.
   always_ff @(posedge clock or negedge in_nReset) begin
      if (!in_nReset) begin
         cnt_q  <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         orig_q <= '0;
         dz_q   <= 1'b0;
      end else if (start_acc) begin
         cnt_q  <= '0;
         dvd_q  <= dvd_mag;
         dvs_q  <= dvs_mag;
         rem_q  <= '0;
         orig_q <= in_Dividend;
         dz_q   <= in_dz;
      end else if (calc_en) begin
         cnt_q  <= cnt_q + CNT_W'(1);
         dvd_q  <= {dvd_q[WIDTH-2:0], step_bit};
         rem_q  <= step_rem;
      end
   end

   always_comb begin
      q_fix = dvd_q;
      r_fix = rem_q;
`ifdef WORD_DIVIDER_SIGNED_EN
      if (neg_quo_q) q_fix = -dvd_q;
      if (neg_rem_q) r_fix = -rem_q;
`endif
      if (dz_q) begin
         q_fix = '1;
         r_fix = orig_q;
      end
   end

   always_ff @(posedge clock or negedge in_nReset) begin
      if (!in_nReset) begin
         out_Done      <= 1'b0;
         out_Quotient  <= '0;
         out_Remainder <= '0;
         out_Zero      <= 1'b0;
         out_Neg       <= 1'b0;
         out_DivZero   <= 1'b0;
      end else begin
         out_Done <= fix_en;
         if (fix_en) begin
            out_Quotient  <= q_fix;
            out_Remainder <= r_fix;
            out_Zero      <= (q_fix == '0);
            out_Neg       <= q_fix[WIDTH-1];
            out_DivZero   <= dz_q;
         end
      end
   end

`ifdef WORD_DIVIDER_SIGNED_EN
   always_ff @(posedge clock or negedge in_nReset) begin
      if (!in_nReset)  out_Overflow <= 1'b0;
      else if (fix_en) out_Overflow <= ovf_q;
   end
`else
   assign out_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_word_divider.sv
// Bench for word_divider: vector table, hand sequences for busy/reset corners,
// and random operands against a plain-arithmetic reference model.
module tb_word_divider;
   import word_divider_pkg::*;

   localparam int W = WORD_WIDTH;
   localparam int DIV_LAT = W + 1;
   typedef logic [W-1:0] word_t;

   typedef struct {
      word_t a;
      word_t b;
      logic  s;
      word_t q;
      word_t r;
      logic  z;
      logic  n;
      logic  o;
      logic  dz;
      int    lat;
   } vec_t;

   logic       clock;
   logic       in_nReset;
   logic       in_Start;
   word_t      in_Dividend;
   word_t      in_Divisor;
`ifdef WORD_DIVIDER_SIGNED_EN
   logic       in_Signed;
`endif
   logic       out_Busy, out_Done, out_Zero, out_Neg, out_Overflow, out_DivZero;
   word_t      out_Quotient, out_Remainder;
   div_state_t out_State;

   int    errors = 0;
   int    checks = 0;
   word_t exp_q[$];
   vec_t  vecs[$];

   word_divider dut (
      .clock         (clock),
      .in_nReset     (in_nReset),
      .in_Start      (in_Start),
      .in_Dividend   (in_Dividend),
      .in_Divisor    (in_Divisor),
`ifdef WORD_DIVIDER_SIGNED_EN
      .in_Signed     (in_Signed),
`endif
      .out_Busy      (out_Busy),
      .out_Done      (out_Done),
      .out_Quotient  (out_Quotient),
      .out_Remainder (out_Remainder),
      .out_Zero      (out_Zero),
      .out_Neg       (out_Neg),
      .out_Overflow  (out_Overflow),
      .out_DivZero   (out_DivZero),
      .out_State     (out_State)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input word_t a, input word_t b, input logic s,
                               input word_t q, input word_t r, input logic z,
                               input logic n, input logic o, input logic dz, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.q = q; v.r = r;
      v.z = z; v.n = n; v.o = o; v.dz = dz; v.lat = lat;
      return v;
   endfunction

   // reference model: plain integer division rules
   function automatic vec_t ref_div(input word_t a, input word_t b, input logic s);
      vec_t v;
      v.a = a; v.b = b; v.s = s; v.o = 1'b0; v.dz = 1'b0;
      if (b == 0) begin
         v.q = '1; v.r = a; v.dz = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         v.q = a; v.r = '0; v.o = 1'b1;
      end else if (s) begin
         v.q = word_t'($signed(a) / $signed(b));
         v.r = word_t'($signed(a) % $signed(b));
      end else begin
         v.q = a / b;
         v.r = a % b;
      end
      v.z   = (v.q == 0);
      v.n   = v.q[W-1];
      v.lat = (b == 0) ? 1 : DIV_LAT;
      return v;
   endfunction

   // driver: assumes the DUT is idle (or in its done cycle) at posedge+1
   task automatic run_check(input vec_t v, input int repulse, input string tag);
      int lat;
      logic seen;
      in_Start = 1'b1; in_Dividend = v.a; in_Divisor = v.b;
`ifdef WORD_DIVIDER_SIGNED_EN
      in_Signed = v.s;
`endif
      @(posedge clock); #1;
      in_Start = 1'b0; in_Dividend = $urandom; in_Divisor = $urandom;
`ifdef WORD_DIVIDER_SIGNED_EN
      in_Signed = 1'($urandom_range(0, 1));
`endif
      check({tag, " busy_after_start"}, 64'(out_Busy), 64'(1));
      check({tag, " done_low_after_start"}, 64'(out_Done), 64'(0));
      lat = 0; seen = 1'b0;
      while (!seen && lat < 80) begin
         if (repulse > 0 && lat == repulse) begin
            in_Start = 1'b1; in_Dividend = 32'd50; in_Divisor = 32'd5;
         end
         @(posedge clock); #1;
         in_Start = 1'b0;
         lat++;
         seen = out_Done;
      end
      exp_q.push_back(v.q);
      exp_q.push_back(v.r);
      check({tag, " done_seen"}, 64'(seen), 64'(1));
      check({tag, " latency"}, 64'(lat), 64'(v.lat));
      check({tag, " busy_in_done"}, 64'(out_Busy), 64'(0));
      check({tag, " quotient"}, 64'(out_Quotient), 64'(exp_q.pop_front()));
      check({tag, " remainder"}, 64'(out_Remainder), 64'(exp_q.pop_front()));
      check({tag, " flags"}, {60'd0, out_Zero, out_Neg, out_Overflow, out_DivZero},
            {60'd0, v.z, v.n, v.o, v.dz});
   endtask

   initial begin
      vec_t v;
      int done_cnt;
      logic sgn;

      in_nReset = 1'b0; in_Start = 1'b0; in_Dividend = '0; in_Divisor = '0;
`ifdef WORD_DIVIDER_SIGNED_EN
      in_Signed = 1'b0;
`endif
      #12;
      check("rst busy", 64'(out_Busy), 64'(0));
      check("rst done", 64'(out_Done), 64'(0));
      check("rst quotient", 64'(out_Quotient), 64'(0));
      check("rst remainder", 64'(out_Remainder), 64'(0));
      check("rst flags", {60'd0, out_Zero, out_Neg, out_Overflow, out_DivZero}, 64'(0));
      check("rst state", 64'(out_State), 64'(DIV_IDLE));
      @(posedge clock); #1;
      in_nReset = 1'b1;
      @(posedge clock); #1;

      //                  a              b              s     q              r              z     n     o     dz    lat
      vecs.push_back(mk(32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'd5,         32'd0,         1'b0, 32'hFFFF_FFFF, 32'd5,         1'b0, 1'b1, 1'b0, 1'b1, 1));
      vecs.push_back(mk(32'd3,         32'd10,        1'b0, 32'd0,         32'd3,         1'b1, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'd0,         32'd5,         1'b0, 32'd0,         32'd0,         1'b1, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'd1000,      32'd0,         1'b0, 32'hFFFF_FFFF, 32'd1000,      1'b0, 1'b1, 1'b0, 1'b1, 1));
`ifdef WORD_DIVIDER_SIGNED_EN
      vecs.push_back(mk(32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 1'b1, 1'b0, 33));
      vecs.push_back(mk(32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 1'b1, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33));
      vecs.push_back(mk(32'hFFFF_FFFB, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 1'b1, 1));
`endif

      // table vectors issued back-to-back from each done cycle
      for (int i = 0; i < vecs.size(); i++) run_check(vecs[i], 0, $sformatf("vec%0d", i));

      // start re-pulsed mid-operation with other operands must be ignored
      run_check(mk(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33), 10, "repulse");

      for (int i = 0; i < 40; i++) begin
         word_t a, b;
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = $urandom_range(1, 20);
            2: b = ($urandom_range(0, 3) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            default: b = $urandom | 32'h8000_0000;
         endcase
         sgn = 1'b0;
`ifdef WORD_DIVIDER_SIGNED_EN
         sgn = 1'($urandom_range(0, 1));
`endif
         v = ref_div(a, b, sgn);
         run_check(v, 0, $sformatf("rnd%0d", i));
      end

      // reset dropped at cycle 15 of a running divide aborts it
      in_Start = 1'b1; in_Dividend = 32'h1234_5678; in_Divisor = 32'd3;
`ifdef WORD_DIVIDER_SIGNED_EN
      in_Signed = 1'b0;
`endif
      @(posedge clock); #1;
      in_Start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      check("abort busy_before", 64'(out_Busy), 64'(1));
      in_nReset = 1'b0;
      #1;
      check("abort busy", 64'(out_Busy), 64'(0));
      check("abort done", 64'(out_Done), 64'(0));
      check("abort quotient", 64'(out_Quotient), 64'(0));
      check("abort remainder", 64'(out_Remainder), 64'(0));
      check("abort flags", {60'd0, out_Zero, out_Neg, out_Overflow, out_DivZero}, 64'(0));
      check("abort state", 64'(out_State), 64'(DIV_IDLE));
      done_cnt = 0;
      repeat (2) begin
         @(posedge clock); #1;
         if (out_Done) done_cnt++;
      end
      in_nReset = 1'b1;
      repeat (40) begin
         @(posedge clock); #1;
         if (out_Done) done_cnt++;
      end
      check("abort no_done", 64'(done_cnt), 64'(0));
      run_check(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 33),
                0, "post_abort");

      // outputs hold after done while idle
      @(posedge clock); #1;
      check("hold done_low", 64'(out_Done), 64'(0));
      check("hold quotient", 64'(out_Quotient), 64'(32'hFFFF_FFFF));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
